risc8_intr_ctrl: RTL and testbench

Interrupt controller for the risc8 core. Edge-detects external interrupt sources and latches them into a pending register. Holds a mask register and selects the highest-priority unmasked pending source. Sequences the request/acknowledge/RETI handshake with the core control unit, which writes the supplied vector through the SR_INTR register-select path and reads the pending flags for GETIF.

---
 rtl/risc8_intr_ctrl.sv | 148 ++++++++++++++
 tb/tb_risc8_intr_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/risc8_intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : risc8_intr_ctrl
// Purpose  : risc8 interrupt controller. Edge-detects the interrupt lines,
//            masks and prioritises them, and runs the request/ack/RETI handshake.
// Option   : RISC8_INTR_NEST_EN allows a higher-priority source to nest during SERVICE.
// Revision : 1.0 - initial release
// ============================================================================
module risc8_intr_ctrl #(
  parameter int         N_SRC      = 4,
  parameter logic [7:0] VEC_BASE   = 8'hF0,
  parameter int         VEC_STRIDE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             ien,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic [N_SRC-1:0] pend_clr,
  output logic             intr_req,
  output logic [7:0]       intr_vec,
  input  logic             intr_ack,
  input  logic             reti,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] in_service,
  output logic [N_SRC-1:0] mask
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [1:0]       state;
  logic [2:0]       sel_idx;
  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] evt;
  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] sel_oh;
  logic [N_SRC-1:0] ack_clr;
  logic [2:0]       cand_idx;
`ifdef RISC8_INTR_NEST_EN
  logic [2:0]       top_idx;
  logic [N_SRC-1:0] top_oh;
  logic [N_SRC-1:0] higher;
  logic [N_SRC-1:0] svc_cand;
  logic [2:0]       svc_idx;
`endif

  // Lowest set index wins; an all-zero vector yields 0 (callers qualify with |v).
  function automatic logic [2:0] lowest_idx(input logic [N_SRC-1:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [7:0] vector_of(input logic [2:0] idx);
    return VEC_BASE + 8'(int'(idx) * VEC_STRIDE);
  endfunction

  always_comb begin
    evt      = irq_src & ~irq_q;
    cand     = pending & mask;
    cand_idx = lowest_idx(cand);
    sel_oh   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      sel_oh[i] = (sel_idx == 3'(i));
    end
    ack_clr  = (state == ST_REQ && intr_ack) ? sel_oh : '0;
`ifdef RISC8_INTR_NEST_EN
    top_idx  = lowest_idx(in_service);
    top_oh   = in_service & (~in_service + N_SRC'(1));
    higher   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      higher[i] = (3'(i) < top_idx);
    end
    svc_cand = cand & higher;
    svc_idx  = lowest_idx(svc_cand);
`endif
  end

  always_ff @(posedge clk) begin
    // irq_q tracks the lines even in reset so a line held high across reset
    // produces no spurious event on release.
    irq_q <= irq_src;
    if (!rst_n) begin
      pending    <= '0;
      mask       <= '0;
      in_service <= '0;
      intr_req   <= 1'b0;
      intr_vec   <= 8'h00;
      sel_idx    <= 3'd0;
      state      <= ST_IDLE;
    end else begin
      pending <= (pending & ~pend_clr & ~ack_clr) | evt;
      if (mask_we) mask <= mask_wdata;

      case (state)
        ST_IDLE: begin
          if (ien && |cand) begin
            sel_idx  <= cand_idx;
            intr_vec <= vector_of(cand_idx);
            intr_req <= 1'b1;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (intr_ack) begin
            intr_req   <= 1'b0;
            in_service <= in_service | sel_oh;
            state      <= ST_SERVICE;
          end else if (!ien) begin
            intr_req <= 1'b0;
            state    <= (|in_service) ? ST_SERVICE : ST_IDLE;
          end
        end
        ST_SERVICE: begin
`ifdef RISC8_INTR_NEST_EN
          // RETI always retires the innermost (highest-priority) active level.
          if (reti) begin
            in_service <= in_service & ~top_oh;
            if (in_service == top_oh) state <= ST_IDLE;
          end else if (ien && |svc_cand) begin
            sel_idx  <= svc_idx;
            intr_vec <= vector_of(svc_idx);
            intr_req <= 1'b1;
            state    <= ST_REQ;
          end
`else
          if (reti) begin
            in_service <= in_service & ~sel_oh;
            state      <= ST_IDLE;
          end
`endif
        end
        default: begin
          intr_req <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_risc8_intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_risc8_intr_ctrl
// Purpose  : Directed and random stimulus for risc8_intr_ctrl against a
//            behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_risc8_intr_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] irq_src;
  logic         ien;
  logic         mask_we;
  logic [N-1:0] mask_wdata;
  logic [N-1:0] pend_clr;
  logic         intr_req;
  logic [7:0]   intr_vec;
  logic         intr_ack;
  logic         reti;
  logic [N-1:0] pending;
  logic [N-1:0] in_service;
  logic [N-1:0] mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  risc8_intr_ctrl #(.N_SRC(N), .VEC_BASE(8'hF0), .VEC_STRIDE(2)) dut (
    .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .ien(ien),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .pend_clr(pend_clr),
    .intr_req(intr_req), .intr_vec(intr_vec), .intr_ack(intr_ack),
    .reti(reti), .pending(pending), .in_service(in_service), .mask(mask)
  );

  // Reference model: phase 0 = waiting, 1 = requesting, 2 = servicing.
  logic [N-1:0] m_prev, m_pend, m_mask, m_isv;
  logic         m_req;
  logic [7:0]   m_vec;
  int           m_cur, m_phase;

  function automatic int lowest(input logic [N-1:0] v);
    int r;
    r = 0;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [7:0] vec_of(input int i);
    return 8'((240 + i * 2) % 256);
  endfunction

  task automatic model_step();
    logic [N-1:0] ev, cand, ack_bit, hc;
    int top;
    ev      = irq_src & ~m_prev;
    cand    = m_pend & m_mask;
    ack_bit = '0;
    m_prev  = irq_src;
    if (!rst_n) begin
      m_pend = '0; m_mask = '0; m_isv = '0; m_req = 1'b0;
      m_vec = 8'h00; m_cur = 0; m_phase = 0;
    end else begin
      if (m_phase == 0) begin
        if (ien && cand != 0) begin
          m_cur = lowest(cand); m_vec = vec_of(m_cur); m_req = 1'b1; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (intr_ack) begin
          ack_bit = N'(1) << m_cur;
          m_isv = m_isv | ack_bit; m_req = 1'b0; m_phase = 2;
        end else if (!ien) begin
          m_req = 1'b0; m_phase = (m_isv != 0) ? 2 : 0;
        end
      end else begin
`ifdef RISC8_INTR_NEST_EN
        if (reti) begin
          m_isv = m_isv & (m_isv - N'(1));
          if (m_isv == 0) m_phase = 0;
        end else begin
          top = lowest(m_isv);
          hc  = cand & ((N'(1) << top) - N'(1));
          if (ien && hc != 0) begin
            m_cur = lowest(hc); m_vec = vec_of(m_cur); m_req = 1'b1; m_phase = 1;
          end
        end
`else
        if (reti) begin
          m_isv = '0; m_phase = 0;
        end
`endif
      end
      m_pend = (m_pend & ~pend_clr & ~ack_bit) | ev;
      if (mask_we) m_mask = mask_wdata;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_req",  32'(intr_req),   32'(m_req));
    chk("model_vec",  32'(intr_vec),   32'(m_vec));
    chk("model_pend", 32'(pending),    32'(m_pend));
    chk("model_isv",  32'(in_service), 32'(m_isv));
    chk("model_mask", 32'(mask),       32'(m_mask));
  endtask

  task automatic quiet();
    mask_we = 1'b0; pend_clr = '0; intr_ack = 1'b0; reti = 1'b0;
  endtask

  initial begin
    m_prev = '0; m_pend = '0; m_mask = '0; m_isv = '0;
    m_req = 1'b0; m_vec = 8'h00; m_cur = 0; m_phase = 0;
    rst_n = 1'b0; irq_src = 4'b1111; ien = 1'b1; quiet();
    mask_we = 1'b1; mask_wdata = 4'b1111;
    tick(); tick();
    chk("rst_req", 32'(intr_req), 32'd0);
    chk("rst_vec", 32'(intr_vec), 32'h00);
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_mask", 32'(mask), 32'd0);
    chk("rst_isv", 32'(in_service), 32'd0);

    // Lines held high across reset must not produce an event.
    rst_n = 1'b1; quiet();
    tick(); tick();
    chk("held_high_pend", 32'(pending), 32'd0);
    mask_we = 1'b1; mask_wdata = 4'b1111; tick(); quiet();
    tick();
    chk("held_high_req", 32'(intr_req), 32'd0);
    irq_src = 4'b0000; tick();

    // Single source 2.
    irq_src = 4'b0100; tick();
    chk("s2_pend", 32'(pending), 32'b0100);
    chk("s2_req_early", 32'(intr_req), 32'd0);
    irq_src = 4'b0000; tick();
    chk("s2_req", 32'(intr_req), 32'd1);
    chk("s2_vec", 32'(intr_vec), 32'hF4);
    intr_ack = 1'b1; tick(); quiet();
    chk("s2_ack_pend", 32'(pending), 32'd0);
    chk("s2_ack_isv", 32'(in_service), 32'b0100);
    reti = 1'b1; tick(); quiet();
    chk("s2_reti_isv", 32'(in_service), 32'd0);
    tick();
    chk("s2_after_req", 32'(intr_req), 32'd0);

    // Simultaneous sources 3 and 1: priority order.
    irq_src = 4'b1010; tick();
    irq_src = 4'b0000; tick();
    chk("pri_first_vec", 32'(intr_vec), 32'hF2);
    intr_ack = 1'b1; tick(); quiet();
    reti = 1'b1; tick(); quiet();
    tick();
    chk("pri_second_req", 32'(intr_req), 32'd1);
    chk("pri_second_vec", 32'(intr_vec), 32'hF6);
    intr_ack = 1'b1; tick(); quiet();
    reti = 1'b1; tick(); quiet();

    // Withdraw on ien drop, then re-raise.
    irq_src = 4'b0010; tick();
    irq_src = 4'b0000; tick();
    chk("wd_req", 32'(intr_req), 32'd1);
    ien = 1'b0; tick();
    chk("wd_dropped", 32'(intr_req), 32'd0);
    chk("wd_pend", 32'(pending), 32'b0010);
    ien = 1'b1; tick();
    chk("wd_reraise", 32'(intr_req), 32'd1);
    chk("wd_vec", 32'(intr_vec), 32'hF2);
    intr_ack = 1'b1; tick(); quiet();
    reti = 1'b1; tick(); quiet();

    // Set beats clear; masked source waits for the mask.
    mask_we = 1'b1; mask_wdata = 4'b1110; tick(); quiet();
    irq_src = 4'b0001; pend_clr = 4'b0001; tick(); quiet();
    chk("setwins_pend", 32'(pending), 32'b0001);
    irq_src = 4'b0000; tick(); tick();
    chk("masked_req", 32'(intr_req), 32'd0);
    mask_we = 1'b1; mask_wdata = 4'b1111; tick(); quiet();
    chk("unmask_req_early", 32'(intr_req), 32'd0);
    tick();
    chk("unmask_req", 32'(intr_req), 32'd1);
    chk("unmask_vec", 32'(intr_vec), 32'hF0);
    intr_ack = 1'b1; tick(); quiet();
    reti = 1'b1; tick(); quiet();

    // Higher-priority source during SERVICE of source 3.
    irq_src = 4'b1000; tick();
    irq_src = 4'b0000; tick();
    chk("nest_outer_vec", 32'(intr_vec), 32'hF6);
    intr_ack = 1'b1; tick(); quiet();
    irq_src = 4'b0001; tick();
    irq_src = 4'b0000; tick();
`ifdef RISC8_INTR_NEST_EN
    chk("nest_req", 32'(intr_req), 32'd1);
    chk("nest_vec", 32'(intr_vec), 32'hF0);
    intr_ack = 1'b1; tick(); quiet();
    chk("nest_isv", 32'(in_service), 32'b1001);
    reti = 1'b1; tick(); quiet();
    chk("nest_reti1", 32'(in_service), 32'b1000);
    tick();
    chk("nest_still_svc", 32'(intr_req), 32'd0);
    reti = 1'b1; tick(); quiet();
    chk("nest_reti2", 32'(in_service), 32'd0);
`else
    chk("nonest_req", 32'(intr_req), 32'd0);
    tick();
    chk("nonest_req2", 32'(intr_req), 32'd0);
    reti = 1'b1; tick(); quiet();
    chk("nonest_isv", 32'(in_service), 32'd0);
    tick();
    chk("nonest_after_req", 32'(intr_req), 32'd1);
    chk("nonest_after_vec", 32'(intr_vec), 32'hF0);
    intr_ack = 1'b1; tick(); quiet();
    reti = 1'b1; tick(); quiet();
`endif
    tick();

    // Randomised traffic, every cycle compared against the model.
    for (int c = 0; c < 1500; c++) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      irq_src    = 4'($urandom) & 4'($urandom);
      ien        = ($urandom_range(0, 7) != 0);
      mask_we    = ($urandom_range(0, 15) == 0);
      mask_wdata = 4'($urandom);
      pend_clr   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      intr_ack   = ($urandom_range(0, 2) == 0);
      reti       = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
